pdm_packet_unpack: RTL

PDM_PACKET_UNPACK -- requirements
Module: pdm_packet_unpack

---
 rtl/pdm_packet_unpack_if.sv | 27 ++
 rtl/pdm_packet_unpack.sv | 112 +++++++++++
 2 files changed

// File: rtl/pdm_packet_unpack_if.sv
// rtl/pdm_packet_unpack_if.sv - byte input and frame output bundle for pdm_packet_unpack
interface pdm_packet_unpack_if #(
  parameter int ERR_BITS = 8
);
  logic [7:0]          rx_byte;
  logic                rx_valid;
  logic [4:0]          frame_ch0;
  logic [4:0]          frame_ch1;
  logic [4:0]          frame_ch2;
  logic [4:0]          frame_ch3;
  logic                frame_valid;
  logic                frame_error;
  logic [ERR_BITS-1:0] err_count;
  logic                in_sync;

  modport master (
    output rx_byte, rx_valid,
    input  frame_ch0, frame_ch1, frame_ch2, frame_ch3,
    input  frame_valid, frame_error, err_count, in_sync
  );

  modport slave (
    input  rx_byte, rx_valid,
    output frame_ch0, frame_ch1, frame_ch2, frame_ch3,
    output frame_valid, frame_error, err_count, in_sync
  );
endinterface

// File: rtl/pdm_packet_unpack.sv
// rtl/pdm_packet_unpack.sv - tagged 4-byte PDM frame decoder with resync and idle timeout
module pdm_packet_unpack #(
  parameter int TIMEOUT_CYCLES = 4800,
  parameter int ERR_BITS       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pdm_packet_unpack_if.slave bus
);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ERR_BITS-1:0] ERR_MAX   = '1;

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t              r_state;
  logic [1:0]          r_exp;
  logic [IDLE_W-1:0]   r_idle;
  logic [4:0]          r_stage [4];
  logic [4:0]          r_ch    [4];
  logic                r_frame_valid;
  logic                r_frame_error;
  logic [ERR_BITS-1:0] r_err_count;
  logic                r_in_sync;

  logic [2:0]          w_tag;
  logic [4:0]          w_sample;
  logic                w_tag_match;
  logic [ERR_BITS-1:0] w_err_next;

  assign w_tag       = bus.rx_byte[7:5];
  assign w_sample    = bus.rx_byte[4:0];
  assign w_tag_match = (w_tag == {1'b0, r_exp});
  assign w_err_next  = (r_err_count == ERR_MAX) ? r_err_count : r_err_count + ERR_BITS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= HUNT;
      r_exp         <= 2'd0;
      r_idle        <= '0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_err_count   <= '0;
      r_in_sync     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_stage[i] <= 5'd0;
        r_ch[i]    <= 5'd0;
      end
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      case (r_state)
        HUNT: begin
          r_idle <= '0;
          if (bus.rx_valid && w_tag == 3'd3) begin
            r_stage[3] <= w_sample;
            r_exp      <= 2'd2;
            r_state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.rx_valid) begin
            r_idle <= '0;
            if (w_tag_match) begin
              r_stage[r_exp] <= w_sample;
              if (r_exp == 2'd0) begin
                // tag-0 sample goes straight to the output; its staging copy is not yet visible
                r_ch[0]       <= w_sample;
                r_ch[1]       <= r_stage[1];
                r_ch[2]       <= r_stage[2];
                r_ch[3]       <= r_stage[3];
                r_frame_valid <= 1'b1;
                r_in_sync     <= 1'b1;
                r_state       <= HUNT;
              end else begin
                r_exp <= r_exp - 2'd1;
              end
            end else begin
              r_frame_error <= 1'b1;
              r_err_count   <= w_err_next;
              r_in_sync     <= 1'b0;
              if (w_tag == 3'd3) begin
                r_stage[3] <= w_sample;
                r_exp      <= 2'd2;
              end else begin
                r_state <= HUNT;
              end
            end
          end else if (r_idle == IDLE_LAST) begin
            r_frame_error <= 1'b1;
            r_err_count   <= w_err_next;
            r_in_sync     <= 1'b0;
            r_idle        <= '0;
            r_state       <= HUNT;
          end else begin
            r_idle <= r_idle + IDLE_W'(1);
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  assign bus.frame_ch0   = r_ch[0];
  assign bus.frame_ch1   = r_ch[1];
  assign bus.frame_ch2   = r_ch[2];
  assign bus.frame_ch3   = r_ch[3];
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_error = r_frame_error;
  assign bus.err_count   = r_err_count;
  assign bus.in_sync     = r_in_sync;
endmodule
